// File: rtl/gate_checker.sv
// -----------------------------------------------------------------------------
// gate_checker
//
// Exerciser for a 2-input combinational gate. On an accepted start it walks
// the gate inputs through vectors 00, 01, 10, 11, holding each for HOLD
// cycles, samples the gate output on the last hold cycle of each vector and
// compares it against a captured 4-bit truth table.
//
// Parameters
//   HOLD   cycles each vector is held (1 .. 2**CNT_W-1)
//   CNT_W  width of the hold counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (accepted in IDLE or DONE)
//   truth      expected y for vector i = {a,b} in truth[i]; captured on accept
//   a, b       gate inputs: vector index bits 1 and 0 while running, else 0
//   y          gate output, combinational from a/b
//   busy       high while a run is in progress
//   done       one-cycle pulse in the cycle after the last sample
//   pass       run result, valid from done until the next accepted start
//   err_count  number of mismatching vectors (0..4)
//   err_mask   err_mask[i] set when vector i mismatched
// -----------------------------------------------------------------------------
module gate_checker #(
    parameter int HOLD  = 10,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] truth,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  hcnt;
    logic [3:0]        truth_q;

    logic accept;      // start taken this edge (IDLE or DONE only)
    logic sample_now;  // last hold cycle of the current vector
    logic last_vec;    // current vector is 11
    logic mismatch;    // sampled y differs from expectation

    always_comb begin
        accept     = start && (state != RUN);
        sample_now = (state == RUN) && (hcnt == HOLD_LAST);
        last_vec   = (idx == 2'd3);
        mismatch   = (y != truth_q[idx]);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours, independent of
    // process ordering in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches whatever path the case statement takes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (sample_now && last_vec) state_next = DONE;
            DONE: state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from flops only, so a/b never depend on y or start.
    // Outside RUN the gate inputs rest at 00 even though idx still holds 3.
    // -------------------------------------------------------------------------
    always_comb begin
        a    = 1'b0;
        b    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN: begin
                a    = idx[1];
                b    = idx[0];
                busy = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: vector index, hold counter, captured truth table and results.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            hcnt      <= '0;
            truth_q   <= 4'd0;
            err_count <= 3'd0;
            err_mask  <= 4'd0;
            pass      <= 1'b0;
        end else if (accept) begin
            idx       <= 2'd0;
            hcnt      <= '0;
            truth_q   <= truth;
            err_count <= 3'd0;
            err_mask  <= 4'd0;
            pass      <= 1'b0;
        end else if (state == RUN) begin
            if (sample_now) begin
                hcnt <= '0;
                if (mismatch) begin
                    err_mask[idx] <= 1'b1;
                    err_count     <= err_count + 3'd1;
                end
                if (!last_vec) begin
                    idx <= idx + 2'd1;
                end else begin
                    // Include this final sample: err_mask has not absorbed it yet.
                    pass <= (err_mask == 4'd0) && !mismatch;
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_checker
//
// Two checker instances share one clock and reset: unit 0 uses HOLD = 10,
// unit 1 uses HOLD = 1. Each drives a gate modelled here as a 4-bit lookup
// table gate_tt[u], so y = gate_tt[u][{a,b}]. Expected results come from the
// table difference gate_tt ^ truth: the mismatch mask, its popcount and
// whether it is empty. Stimulus and sampling happen on the falling edge.
// -----------------------------------------------------------------------------
module tb_gate_checker;

    logic       clk;
    logic       rst_n;
    logic       start_s   [2];
    logic [3:0] truth_s   [2];
    logic       a_s       [2];
    logic       b_s       [2];
    logic       y_s       [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic       pass_s    [2];
    logic [2:0] ec_s      [2];
    logic [3:0] em_s      [2];
    logic [3:0] gate_tt   [2];

    int n_pass  = 0;
    int n_total = 0;

    gate_checker #(.HOLD(10), .CNT_W(8)) u_slow (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[0]),
        .truth     (truth_s[0]),
        .a         (a_s[0]),
        .b         (b_s[0]),
        .y         (y_s[0]),
        .busy      (busy_s[0]),
        .done      (done_s[0]),
        .pass      (pass_s[0]),
        .err_count (ec_s[0]),
        .err_mask  (em_s[0])
    );

    gate_checker #(.HOLD(1), .CNT_W(8)) u_fast (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[1]),
        .truth     (truth_s[1]),
        .a         (a_s[1]),
        .b         (b_s[1]),
        .y         (y_s[1]),
        .busy      (busy_s[1]),
        .done      (done_s[1]),
        .pass      (pass_s[1]),
        .err_count (ec_s[1]),
        .err_mask  (em_s[1])
    );

    // Gates under test: combinational lookup on the driven inputs.
    assign y_s[0] = gate_tt[0][{a_s[0], b_s[0]}];
    assign y_s[1] = gate_tt[1][{a_s[1], b_s[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete run on unit u, from the accepting edge to the done cycle.
    // Returns positioned at the falling edge inside the done cycle.
    //   pulse_mid : pulse start at run cycles 5 and 25 (must be ignored)
    //   early     : raise start in the last run cycle and keep it through done
    task automatic do_run(input int u, input logic [3:0] gtt, input logic [3:0] ett,
                          input bit pulse_mid, input bit early);
        int         h;
        int         n_sampled;
        int         vec;
        logic [3:0] mask;
        logic [3:0] part;
        h    = (u == 0) ? 10 : 1;
        mask = gtt ^ ett;
        gate_tt[u] = gtt;
        truth_s[u] = ett;
        start_s[u] = 1'b1;
        @(posedge clk);              // accepting edge E0
        @(negedge clk);              // inside cycle 1
        start_s[u] = 1'b0;
        truth_s[u] = ~ett;           // must not affect the captured table
        for (int k = 1; k <= 4 * h; k++) begin
            vec       = (k - 1) / h;
            n_sampled = (k - 1) / h;
            part      = mask & 4'((1 << n_sampled) - 1);
            check($sformatf("u%0d busy k=%0d", u, k), 8'(busy_s[u]), 8'd1);
            check($sformatf("u%0d done k=%0d", u, k), 8'(done_s[u]), 8'd0);
            check($sformatf("u%0d ab k=%0d", u, k), 8'({a_s[u], b_s[u]}), 8'(vec));
            check($sformatf("u%0d err_mask k=%0d", u, k), 8'(em_s[u]), 8'(part));
            check($sformatf("u%0d err_count k=%0d", u, k), 8'(ec_s[u]), 8'($countones(part)));
            check($sformatf("u%0d pass k=%0d", u, k), 8'(pass_s[u]), 8'd0);
            start_s[u] = (pulse_mid && (k == 5 || k == 25)) || (early && k == 4 * h);
            @(negedge clk);
        end
        // Done cycle: 4*HOLD+1 cycles after the accepting edge.
        check($sformatf("u%0d done pulse", u), 8'(done_s[u]), 8'd1);
        check($sformatf("u%0d busy at done", u), 8'(busy_s[u]), 8'd0);
        check($sformatf("u%0d ab at done", u), 8'({a_s[u], b_s[u]}), 8'd0);
        check($sformatf("u%0d final err_mask", u), 8'(em_s[u]), 8'(mask));
        check($sformatf("u%0d final err_count", u), 8'(ec_s[u]), 8'($countones(mask)));
        check($sformatf("u%0d final pass", u), 8'(pass_s[u]), 8'(mask == 4'd0));
    endtask

    // Cycle after a done with no restart: back in IDLE, result retained.
    task automatic idle_check(input int u, input logic exp_pass);
        @(negedge clk);
        check($sformatf("u%0d idle done", u), 8'(done_s[u]), 8'd0);
        check($sformatf("u%0d idle busy", u), 8'(busy_s[u]), 8'd0);
        check($sformatf("u%0d idle pass held", u), 8'(pass_s[u]), 8'(exp_pass));
    endtask

    initial begin
        bit         seen_done;
        logic [3:0] g;
        logic [3:0] t;
        int         u;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            truth_s[i] = 4'd0;
            gate_tt[i] = 4'd0;
        end
        #12;
        // Reset values of both units.
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d rst a", i), 8'(a_s[i]), 8'd0);
            check($sformatf("u%0d rst b", i), 8'(b_s[i]), 8'd0);
            check($sformatf("u%0d rst busy", i), 8'(busy_s[i]), 8'd0);
            check($sformatf("u%0d rst done", i), 8'(done_s[i]), 8'd0);
            check($sformatf("u%0d rst pass", i), 8'(pass_s[i]), 8'd0);
            check($sformatf("u%0d rst err_count", i), 8'(ec_s[i]), 8'd0);
            check($sformatf("u%0d rst err_mask", i), 8'(em_s[i]), 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // OR gate, with start pulses during the run that must be ignored.
        do_run(0, 4'b1110, 4'b1110, 1'b1, 1'b0);
        idle_check(0, 1'b1);

        // AND gate, then restarts held through DONE to check the clearing.
        do_run(0, 4'b1000, 4'b1110, 1'b0, 1'b1);
        do_run(0, 4'b1110, 4'b1110, 1'b0, 1'b1);   // err_count 2 -> cleared
        do_run(0, 4'b1111, 4'b1110, 1'b0, 1'b0);   // y tied 1, pass 1 -> cleared
        idle_check(0, 1'b0);
        do_run(0, 4'b0000, 4'b1110, 1'b0, 1'b0);   // y tied 0
        idle_check(0, 1'b0);

        // HOLD = 1 unit: OR passes, AND fails, back-to-back.
        do_run(1, 4'b1110, 4'b1110, 1'b0, 1'b1);
        do_run(1, 4'b1000, 4'b1110, 1'b0, 1'b0);
        idle_check(1, 1'b0);

        // Reset in the middle of a run on unit 0 (y tied 1, one error by now).
        gate_tt[0] = 4'b1111;
        truth_s[0] = 4'b1110;
        start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (14) @(negedge clk);                 // cycle 15: vector 01
        check("mid-run ab before reset", 8'({a_s[0], b_s[0]}), 8'd1);
        check("mid-run err_count before reset", 8'(ec_s[0]), 8'd1);
        rst_n = 1'b0;
        #1;
        check("reset a", 8'(a_s[0]), 8'd0);
        check("reset b", 8'(b_s[0]), 8'd0);
        check("reset busy", 8'(busy_s[0]), 8'd0);
        check("reset err_count", 8'(ec_s[0]), 8'd0);
        check("reset err_mask", 8'(em_s[0]), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_s[0] !== 1'b0) seen_done = 1'b1;
        end
        check("no done after aborted run", 8'(seen_done), 8'd0);
        do_run(0, 4'b1110, 4'b1110, 1'b0, 1'b0);
        idle_check(0, 1'b1);

        // Random gates against random expectations on either unit.
        for (int r = 0; r < 10; r++) begin
            u = int'($urandom_range(0, 1));
            g = 4'($urandom);
            t = 4'($urandom);
            do_run(u, g, t, 1'b0, 1'b0);
            idle_check(u, g == t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
